// File: rtl/fpnew_opgroup_retire_buffer.sv
// In-order retirement FIFO behind one opgroup block, with sticky fflags accumulation.
// Optional zero-latency cut-through on an empty buffer: define FPNEW_RETIRE_BYPASS_EN.
module fpnew_opgroup_retire_buffer #(
  parameter int unsigned Width    = 32,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned Depth    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [Width-1:0]             in_result_i,
  input  logic [4:0]                   in_status_i,
  input  logic                         in_ext_bit_i,
  input  logic [TagWidth-1:0]          in_tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             out_result_o,
  output logic [4:0]                   out_status_o,
  output logic                         out_ext_bit_o,
  output logic [TagWidth-1:0]          out_tag_o,
  input  logic                         fflags_clr_i,
  output logic [4:0]                   fflags_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  logic [Width-1:0]    mem_result [Depth];
  logic [4:0]          mem_status [Depth];
  logic                mem_ext    [Depth];
  logic [TagWidth-1:0] mem_tag    [Depth];

  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;
  logic [4:0]      fflags;
  logic            empty;
  logic            out_fire;
  logic            fifo_push;
  logic            fifo_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty         = (count == '0);
    in_ready_o    = (count < DepthCnt) & ~flush_i;
    out_valid_o   = ~empty & ~flush_i;
    out_result_o  = '0;
    out_status_o  = '0;
    out_ext_bit_o = 1'b0;
    out_tag_o     = '0;
    if (out_valid_o) begin
      out_result_o  = mem_result[rd_ptr];
      out_status_o  = mem_status[rd_ptr];
      out_ext_bit_o = mem_ext[rd_ptr];
      out_tag_o     = mem_tag[rd_ptr];
    end
`ifdef FPNEW_RETIRE_BYPASS_EN
    if (empty & ~flush_i) begin
      out_valid_o = in_valid_i;
      if (in_valid_i) begin
        out_result_o  = in_result_i;
        out_status_o  = in_status_i;
        out_ext_bit_o = in_ext_bit_i;
        out_tag_o     = in_tag_i;
      end
    end
`endif
    out_fire  = out_valid_o & out_ready_i;
    fifo_push = in_valid_i & in_ready_o;
    fifo_pop  = out_fire;
`ifdef FPNEW_RETIRE_BYPASS_EN
    // On an empty buffer a retiring entry came straight from the input, never from storage.
    if (empty) begin
      fifo_pop = 1'b0;
      if (out_ready_i) fifo_push = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      mem_result[wr_ptr] <= in_result_i;
      mem_status[wr_ptr] <= in_status_i;
      mem_ext[wr_ptr]    <= in_ext_bit_i;
      mem_tag[wr_ptr]    <= in_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
        if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (fifo_push & ~fifo_pop)      count <= count + 1'b1;
        else if (fifo_pop & ~fifo_push) count <= count - 1'b1;
      end
      // Clear takes effect before the retiring entry's flags are folded in.
      fflags <= (fflags_clr_i ? 5'b0 : fflags) | (out_fire ? out_status_o : 5'b0);
    end
  end

  assign fflags_o = fflags;
  assign count_o  = count;
  assign busy_o   = (count != '0);

endmodule

// File: tb/tb_fpnew_opgroup_retire_buffer.sv
// Scoreboard bench for fpnew_opgroup_retire_buffer: directed pushes queue expected
// entries, an independent monitor checks each retired entry in order.
module tb_fpnew_opgroup_retire_buffer;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    logic        t;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o;
  logic [31:0] in_result_i;
  logic [4:0]  in_status_i;
  logic        in_ext_bit_i;
  logic [0:0]  in_tag_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_status_o;
  logic        out_ext_bit_o;
  logic [0:0]  out_tag_o;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic [2:0]  count_o;
  logic        busy_o;

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t expq[$];

  always #5 clk = ~clk;

  fpnew_opgroup_retire_buffer #(.Width(32), .TagWidth(1), .Depth(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_result_i(in_result_i), .in_status_i(in_status_i),
    .in_ext_bit_i(in_ext_bit_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_status_o(out_status_o),
    .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
    .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an item and hold it until accepted; optionally record it as expected output.
  task automatic send(input item_t it, input bit expect_out);
    bit acc;
    in_valid_i   = 1'b1;
    in_result_i  = it.r;
    in_status_i  = it.s;
    in_ext_bit_i = it.e;
    in_tag_i     = it.t;
    if (expect_out) expq.push_back(it);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b0;
  endtask

  // Monitor: every retiring entry must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (expq.size() == 0) begin
        check("unexpected_retire", {27'd0, out_result_o, out_status_o}, 64'd0);
      end else begin
        item_t e;
        e = expq.pop_front();
        check("retire_data", {25'd0, out_result_o, out_status_o, out_ext_bit_o, out_tag_o},
              {25'd0, e});
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_result_i = '0;
    in_status_i = '0; in_ext_bit_i = 1'b0; in_tag_i = '0;
    out_ready_i = 1'b0; fflags_clr_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count", count_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_fflags", fflags_o, 0);
    check("rst_out_result", out_result_o, 0);
    tick();

    // Basic flow: one-cycle latency, fflags absorb status on retire
    out_ready_i = 1'b1;
    send('{r: 32'h3F800000, s: 5'b00001, e: 1'b0, t: 1'b1}, 1'b1);
    @(negedge clk);
    check("basic_out_valid", out_valid_o, 1);
    check("basic_count", count_o, 1);
    tick();
    @(negedge clk);
    check("basic_count_after", count_o, 0);
    check("basic_fflags", fflags_o, 5'b00001);
    tick();

    // Full / backpressure: A..D fill, E held upstream
    out_ready_i = 1'b0;
    send('{r: 32'hA0A0A0A0, s: 5'b0, e: 1'b1, t: 1'b0}, 1'b1);
    send('{r: 32'hB1B1B1B1, s: 5'b0, e: 1'b0, t: 1'b1}, 1'b1);
    send('{r: 32'hC2C2C2C2, s: 5'b0, e: 1'b1, t: 1'b1}, 1'b1);
    send('{r: 32'hD3D3D3D3, s: 5'b0, e: 1'b0, t: 1'b0}, 1'b1);
    @(negedge clk);
    check("full_count", count_o, 4);
    check("full_in_ready", in_ready_o, 0);
    check("full_busy", busy_o, 1);
    tick();
    fork
      send('{r: 32'hE4E4E4E4, s: 5'b0, e: 1'b1, t: 1'b0}, 1'b1);
      begin
        tick(); tick();
        @(negedge clk);
        check("full_hold_count", count_o, 4);
        check("full_no_passthru", in_ready_o, 0);
        tick();
        out_ready_i = 1'b1;
      end
    join
    for (int i = 0; i < 20 && count_o != 0; i++) tick();
    @(negedge clk);
    check("drain_count", count_o, 0);
    check("drain_fflags", fflags_o, 5'b00001);
    tick();

    // Clear alone, then clear coinciding with a pop
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    @(negedge clk);
    check("clr_fflags", fflags_o, 0);
    tick();
    send('{r: 32'h11111111, s: 5'b10000, e: 1'b0, t: 1'b0}, 1'b1);
    tick();
    @(negedge clk);
    check("nv_fflags", fflags_o, 5'b10000);
    tick();
    out_ready_i = 1'b0;
    send('{r: 32'h22222222, s: 5'b00100, e: 1'b0, t: 1'b1}, 1'b1);
    out_ready_i = 1'b1;
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    @(negedge clk);
    check("clr_pop_fflags", fflags_o, 5'b00100);
    check("clr_pop_count", count_o, 0);
    tick();

    // Flush with three entries buffered and a concurrent input
    out_ready_i = 1'b0;
    send('{r: 32'h33330001, s: 5'b00010, e: 1'b0, t: 1'b0}, 1'b0);
    send('{r: 32'h33330002, s: 5'b00010, e: 1'b0, t: 1'b0}, 1'b0);
    send('{r: 32'h33330003, s: 5'b00010, e: 1'b0, t: 1'b0}, 1'b0);
    @(negedge clk);
    check("preflush_count", count_o, 3);
    tick();
    flush_i = 1'b1; in_valid_i = 1'b1; in_result_i = 32'h44444444; in_status_i = 5'b01000;
    @(negedge clk);
    check("flush_in_ready", in_ready_o, 0);
    check("flush_out_valid", out_valid_o, 0);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    check("postflush_count", count_o, 0);
    check("postflush_out_valid", out_valid_o, 0);
    check("postflush_busy", busy_o, 0);
    check("postflush_fflags", fflags_o, 5'b00100);
    out_ready_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("flush_input_dropped", count_o, 0);
    tick();

    // Reset mid-operation with all flags set
    send('{r: 32'h55555555, s: 5'b11111, e: 1'b1, t: 1'b1}, 1'b1);
    tick();
    @(negedge clk);
    check("all_fflags", fflags_o, 5'b11111);
    tick();
    out_ready_i = 1'b0;
    send('{r: 32'h66660001, s: 5'b0, e: 1'b0, t: 1'b0}, 1'b0);
    send('{r: 32'h66660002, s: 5'b0, e: 1'b0, t: 1'b0}, 1'b0);
    @(negedge clk);
    check("prereset_count", count_o, 2);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_count", count_o, 0);
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_fflags", fflags_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    tick();

`ifdef FPNEW_RETIRE_BYPASS_EN
    // Cut-through on an empty buffer
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_result_i = 32'h40000000; in_status_i = 5'b01000;
    in_ext_bit_i = 1'b0; in_tag_i = 1'b1;
    expq.push_back('{r: 32'h40000000, s: 5'b01000, e: 1'b0, t: 1'b1});
    @(negedge clk);
    check("byp_out_valid", out_valid_o, 1);
    check("byp_out_result", out_result_o, 32'h40000000);
    tick();
    in_valid_i = 1'b0;
    @(negedge clk);
    check("byp_count", count_o, 0);
    check("byp_fflags", fflags_o, 5'b01000);
    tick();
`else
    // No combinational in->out path: entry appears only after the edge
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_result_i = 32'h40000000; in_status_i = 5'b01000;
    in_ext_bit_i = 1'b0; in_tag_i = 1'b1;
    expq.push_back('{r: 32'h40000000, s: 5'b01000, e: 1'b0, t: 1'b1});
    @(negedge clk);
    check("nobyp_out_valid", out_valid_o, 0);
    check("nobyp_out_result", out_result_o, 0);
    tick();
    in_valid_i = 1'b0;
    @(negedge clk);
    check("nobyp_latency_valid", out_valid_o, 1);
    tick();
    @(negedge clk);
    check("nobyp_count", count_o, 0);
    check("nobyp_fflags", fflags_o, 5'b01000);
    tick();
`endif

    for (int i = 0; i < 20 && expq.size() != 0; i++) tick();
    check("scoreboard_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
